// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, flag bit positions,
// FSM state encoding and opcode-class helpers.
package alu_pkg;

    localparam logic [4:0] OP_INC = 5'b00001;
    localparam logic [4:0] OP_DEC = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SBB = 5'b00111;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;
    localparam logic [4:0] OP_SHL = 5'b10000;
    localparam logic [4:0] OP_SHR = 5'b10001;
    localparam logic [4:0] OP_SAL = 5'b10010;
    localparam logic [4:0] OP_SAR = 5'b10011;
    localparam logic [4:0] OP_ROL = 5'b10100;
    localparam logic [4:0] OP_ROR = 5'b10101;
    localparam logic [4:0] OP_RCL = 5'b10110;
    localparam logic [4:0] OP_RCR = 5'b10111;

    // Flag vector is {CF,ZF,NF,VF,PF,AF}
    localparam int F_CF = 5;
    localparam int F_ZF = 4;
    localparam int F_NF = 3;
    localparam int F_VF = 2;
    localparam int F_PF = 1;
    localparam int F_AF = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    function automatic logic op_is_arith(input logic [4:0] op);
        return op inside {OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB};
    endfunction

    function automatic logic op_is_logic(input logic [4:0] op);
        return op[4:2] == 3'b010;
    endfunction

    function automatic logic op_is_shift(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_legal_op(input logic [4:0] op);
        return op_is_arith(op) || op_is_logic(op) || op_is_shift(op);
    endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational 16-bit ALU.
// Ports: a_i/b_i operands, f_i opcode, cin_i carry in,
//        result_o result, status_o flags {CF,ZF,NF,VF,PF,AF}.
// Shifts/rotates move by one bit and ignore b_i. PF is even parity over
// all 16 result bits. AF is the nibble carry/borrow, arithmetic only.
module alu_seq_alu
    import alu_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [4:0]  f_i,
    input  logic        cin_i,
    output logic [15:0] result_o,
    output logic [5:0]  status_o
);

    logic [15:0] bv;
    logic        sub;
    logic        c;
    logic [16:0] sum;
    logic [4:0]  nib;
    logic [15:0] res;
    logic        cf, vf, af;

    // Shared add/subtract path; INC/DEC reuse it with an operand of 1
    always_comb begin
        bv  = b_i;
        sub = 1'b0;
        c   = 1'b0;
        case (f_i)
            OP_INC: bv = 16'd1;
            OP_DEC: begin bv = 16'd1; sub = 1'b1; end
            OP_ADC: c = cin_i;
            OP_SUB: sub = 1'b1;
            OP_SBB: begin sub = 1'b1; c = cin_i; end
            default: ;
        endcase
        if (sub) begin
            sum = {1'b0, a_i} - {1'b0, bv} - {16'd0, c};
            nib = {1'b0, a_i[3:0]} - {1'b0, bv[3:0]} - {4'd0, c};
        end else begin
            sum = {1'b0, a_i} + {1'b0, bv} + {16'd0, c};
            nib = {1'b0, a_i[3:0]} + {1'b0, bv[3:0]} + {4'd0, c};
        end
    end

    always_comb begin
        res = 16'd0;
        cf  = 1'b0;
        vf  = 1'b0;
        af  = 1'b0;
        case (f_i)
            OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                res = sum[15:0];
                cf  = sum[16];
                af  = nib[4];
                vf  = sub ? ((a_i[15] != bv[15]) && (res[15] != a_i[15]))
                          : ((a_i[15] == bv[15]) && (res[15] != a_i[15]));
            end
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_NOT: res = ~a_i;
            OP_SHL, OP_SAL: begin res = {a_i[14:0], 1'b0};    cf = a_i[15]; end
            OP_SHR:         begin res = {1'b0, a_i[15:1]};    cf = a_i[0];  end
            OP_SAR:         begin res = {a_i[15], a_i[15:1]}; cf = a_i[0];  end
            OP_ROL:         begin res = {a_i[14:0], a_i[15]}; cf = a_i[15]; end
            OP_ROR:         begin res = {a_i[0], a_i[15:1]};  cf = a_i[0];  end
            OP_RCL:         begin res = {a_i[14:0], cin_i};   cf = a_i[15]; end
            OP_RCR:         begin res = {cin_i, a_i[15:1]};   cf = a_i[0];  end
            default: ;
        endcase
    end

    assign result_o = res;
    assign status_o = {cf, (res == 16'd0), res[15], vf, ~^res, af};

endmodule

// File: rtl/alu_seq.sv
// ALU sequencer: 8x16 register file + flags register in front of the ALU.
// Ports: clk/rst (async high); load_en/load_addr/load_data external register
//        write (IDLE only, beats instructions); instr_valid/instr_ready/instr
//        instruction handshake, instr = {op,rd,rs1,rs2}; done/err one-cycle
//        completion pulses; result last written-back value; flags {CF,ZF,NF,VF,PF,AF}.
module alu_seq
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int W    = 16,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [W-1:0]    load_data,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [4+3*AW:0] instr,
    output logic            done,
    output logic            err,
    output logic [W-1:0]    result,
    output logic [5:0]      flags
);

    state_t        state_q;
    logic [W-1:0]  regs_q [NREG];
    logic [W-1:0]  opa_q, opb_q, wb_data_q, result_q;
    logic [4:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [5:0]    wb_flags_q, flags_q;
    logic          done_q, err_q;

    logic [W-1:0]  alu_res;
    logic [5:0]    alu_status;
    logic [5:0]    wb_flags_d;

    logic [4:0]    f_op;
    logic [AW-1:0] f_rd, f_rs1, f_rs2;

    assign f_op  = instr[4+3*AW -: 5];
    assign f_rd  = instr[3*AW-1 -: AW];
    assign f_rs1 = instr[2*AW-1 -: AW];
    assign f_rs2 = instr[AW-1:0];

    // Carry-in is the stored CF, so ADC/SBB/RCL/RCR chain across instructions
    alu_seq_alu u_alu (
        .a_i      (opa_q),
        .b_i      (opb_q),
        .f_i      (op_q),
        .cin_i    (flags_q[F_CF]),
        .result_o (alu_res),
        .status_o (alu_status)
    );

    always_comb begin
        wb_flags_d = alu_status;
        if (op_is_logic(op_q)) begin
            wb_flags_d[F_CF] = 1'b0;
            wb_flags_d[F_VF] = 1'b0;
        end else if (op_is_shift(op_q)) begin
            wb_flags_d[F_VF] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            wb_flags_q <= '0;
            flags_q    <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_en) begin
                        regs_q[load_addr] <= load_data;
                    end else if (instr_valid) begin
                        // Operands sampled here, so rd aliasing rs1/rs2 is safe
                        opa_q   <= regs_q[f_rs1];
                        opb_q   <= regs_q[f_rs2];
                        op_q    <= f_op;
                        rd_q    <= f_rd;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wb_data_q  <= alu_res;
                    wb_flags_q <= wb_flags_d;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    if (is_legal_op(op_q)) begin
                        regs_q[rd_q] <= wb_data_q;
                        result_q     <= wb_data_q;
                        flags_q      <= wb_flags_q;
                        done_q       <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE) && !load_en;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;
    assign flags       = flags_q;

endmodule
